// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SBC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier, low WIDTH bits of the product only.
// start loads the operands; WIDTH iterations follow. done is high during the
// last iteration and product then carries the final (next-accumulator) value.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CW'(1));
  assign product  = acc_next;

  // Load on start, otherwise step one bit per cycle while iterations remain.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
    end else if (busy) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_next;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Only the iteration counter needs a reset; datapath is reloaded on start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and registered Result/NZCV.
// Build option: define ALU_MUL_EN to include the iterative multiplier and the
// MUL state; without it opcode 111 completes in one cycle with Result 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic             go_mul;
  logic             mul_idle;
  logic [WIDTH-1:0] b_op;
  logic             ci;
  logic             is_arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_flag;
  logic             v_flag;

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign go_mul    = (ALUControl == OP_MUL);
  assign mul_start = accept && go_mul;
  assign mul_idle  = !mul_busy;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign go_mul   = 1'b0;
  assign mul_idle = 1'b1;
`endif

  assign in_ready  = !reset && mul_idle &&
                     ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign ALUFlags  = flags_q;

  // Shared adder: subtraction is a + ~b + carry-in.
  always_comb begin
    b_op     = b;
    ci       = 1'b0;
    is_arith = 1'b0;
    case (ALUControl)
      OP_ADD: is_arith = 1'b1;
      OP_SUB: begin b_op = ~b; ci = 1'b1; is_arith = 1'b1; end
      OP_ADC: begin ci = cin; is_arith = 1'b1; end
      OP_SBC: begin b_op = ~b; ci = cin; is_arith = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, ci};
  end

  // Single-cycle result select and the carry/overflow flags it implies.
  always_comb begin
    case (ALUControl)
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_EOR:  alu_res = a ^ b;
      OP_MUL:  alu_res = '0;
      default: alu_res = sum[WIDTH-1:0];
    endcase
    c_flag = is_arith && sum[WIDTH];
    v_flag = is_arith && (a[WIDTH-1] == b_op[WIDTH-1]) &&
             (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Next state and result capture; a new accept overrides the DONE->IDLE exit.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: ;
`ifdef ALU_MUL_EN
      MUL: begin
        if (mul_done) begin
          state_d  = DONE;
          result_d = mul_prod;
          flags_d  = make_flags(mul_prod, 1'b0, 1'b0);
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (go_mul) begin
        state_d = MUL;
      end else begin
        state_d  = DONE;
        result_d = alu_res;
        flags_d  = make_flags(alu_res, c_flag, v_flag);
      end
    end
  end

  // Control and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed + randomised bench for alu_mc with a scoreboard of expected results.
module tb_alu_mc;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [2:0]  alu_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .ALUControl (alu_ctl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [2:0] op, logic [31:0] x, logic [31:0] y, logic c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cf;
    logic        vf;
    exp_t        e;
`ifdef ALU_MUL_EN
    logic [63:0] p;
`endif
    s  = '0;
    r  = '0;
    cf = 1'b0;
    vf = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, x} + {1'b0, y}; r = s[31:0]; cf = s[32];
        vf = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'b001: begin
        r = x - y; cf = (x >= y);
        vf = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: begin
        s = {1'b0, x} + {1'b0, y} + {32'b0, c}; r = s[31:0]; cf = s[32];
        vf = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'b110: begin
        r = x - y - {31'b0, !c};
        cf = ({1'b0, x} >= ({1'b0, y} + {32'b0, !c}));
        vf = (x[31] != y[31]) && (r[31] != x[31]);
      end
      default: begin
`ifdef ALU_MUL_EN
        p = {32'b0, x} * {32'b0, y};
        r = p[31:0];
`else
        r = 32'b0;
`endif
      end
    endcase
    e.res = r;
    e.flg = {r[31], (r == 32'b0), cf, vf};
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [2:0] op, logic [31:0] x, logic [31:0] y, logic c);
    in_valid = 1'b1;
    alu_ctl  = op;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  // Sample mid-cycle: pop/compare on an output handshake, push on an input one.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_result", 64'(Result), 64'(e.res));
        chk("sb_flags", 64'(ALUFlags), 64'(e.flg));
      end
    end
    if (in_valid && in_ready) sb.push_back(model(alu_ctl, a, b, cin));
    @(negedge clk);
  endtask

  task automatic drain(int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) tick();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int   n0;
    int   lat;
    int   irz;
    exp_t eo;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    alu_ctl   = 3'b000;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_flags", 64'(ALUFlags), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // ADD wrap with one-cycle latency
    drive(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("add_latency", 64'(out_valid), 64'd1);
    chk("add_result", 64'(Result), 64'h0);
    chk("add_flags", 64'(ALUFlags), 64'b0110);
    out_ready = 1'b1;
    tick();

    // SUB, SBC, ADC, EOR back to back with out_ready held high
    n0 = n_out;
    drive(3'b001, 32'h8000_0000, 32'h0000_0001, 1'b0); tick();
    drive(3'b110, 32'd5, 32'd3, 1'b0);                 tick();
    drive(3'b101, 32'd5, 32'd3, 1'b1);                 tick();
    drive(3'b100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    chk("b2b_count", 64'(n_out - n0), 64'd4);
    chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: result held while out_ready low
    out_ready = 1'b0;
    drive(3'b011, 32'h1200_0034, 32'h8000_5600, 1'b0);
    eo = model(3'b011, 32'h1200_0034, 32'h8000_5600, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_result", 64'(Result), 64'(eo.res));
      chk("bp_flags", 64'(ALUFlags), 64'(eo.flg));
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive(3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_new_op_done", 64'(out_valid), 64'd1);
    tick();
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

`ifdef ALU_MUL_EN
    // MUL latency, busy in_ready, and in_valid ignored while multiplying
    out_ready = 1'b0;
    drive(3'b111, 32'h0001_0000, 32'h0001_0000, 1'b0);
    tick();
    drive(3'b000, 32'd1, 32'd2, 1'b0);
    lat = 0;
    irz = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (!in_ready) irz++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mul_latency", 64'(lat), 64'd33);
    chk("mul_in_ready_low", 64'(irz), 64'd32);
    chk("mul_result", 64'(Result), 64'h0);
    chk("mul_flags", 64'(ALUFlags), 64'b0100);
    out_ready = 1'b1;
    tick();

    drive(3'b111, 32'd7, 32'd6, 1'b0);                 tick();
    in_valid = 1'b0;
    drain(60);
    chk("mul7x6_result", 64'(Result), 64'h2A);
    drive(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0); tick();
    in_valid = 1'b0;
    drain(60);
    drive(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); tick();
    in_valid = 1'b0;
    drain(60);
`else
    // Without the multiplier, opcode 111 finishes in one cycle with Z set
    out_ready = 1'b0;
    drive(3'b111, 32'd7, 32'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("nomul_latency", 64'(out_valid), 64'd1);
    chk("nomul_result", 64'(Result), 64'h0);
    chk("nomul_flags", 64'(ALUFlags), 64'b0100);
    out_ready = 1'b1;
    tick();
`endif

    // Randomised traffic with random backpressure
    for (int i = 0; i < 24; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      alu_ctl   = 3'($urandom_range(0, 7));
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(300);

    // Leave a non-zero result behind, then reset in the middle of an operation
    drive(3'b000, 32'd1, 32'd1, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
`ifdef ALU_MUL_EN
    drive(3'b111, 32'd3, 32'd5, 1'b0);
`else
    drive(3'b001, 32'd9, 32'd4, 1'b0);
`endif
    tick();
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(Result), 64'h0);
    chk("midrst_flags", 64'(ALUFlags), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (40) tick();
    chk("midrst_no_stale", 64'(n_out - n0), 64'd0);

    // Fresh op after the abort still works
    drive(3'b001, 32'd5, 32'd7, 1'b0); tick();
    in_valid = 1'b0;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
